// File: rtl/bp_be_wb_merge.sv
// Writeback merge buffer: collects register writebacks from several pipes in age order and
// drains up to two per cycle onto the register file. Optional counters: BP_BE_WB_MERGE_STATS_EN.
module bp_be_wb_merge #(
    parameter int reg_addr_width_gp = 5,
    parameter int data_width_p      = 64,
    parameter int sources_p         = 4,
    parameter int els_p             = 8,
    parameter bit zero_x0_p         = 1'b1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [sources_p-1:0]                   src_v_i,
    input  logic [sources_p*reg_addr_width_gp-1:0] src_addr_i,
    input  logic [sources_p*data_width_p-1:0]      src_data_i,
    output logic [sources_p-1:0]                   src_ready_o,
    output logic [1:0]                             rd_w_v_o,
    output logic [2*reg_addr_width_gp-1:0]         rd_addr_o,
    output logic [2*data_width_p-1:0]              rd_data_o,
    output logic                                   empty_o,
    output logic [$clog2(els_p+1)-1:0]             count_o
`ifdef BP_BE_WB_MERGE_STATS_EN
    ,
    output logic [31:0]                            stat_writes_o,
    output logic [31:0]                            stat_waw_drops_o,
    output logic [31:0]                            stat_stall_o
`endif
);

    localparam int AW = reg_addr_width_gp;
    localparam int DW = data_width_p;
    localparam int PW = $clog2(els_p);
    localparam int CW = $clog2(els_p+1);

    logic [AW-1:0] r_mem_addr [els_p];
    logic [DW-1:0] r_mem_data [els_p];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [CW-1:0]        w_free;
    logic [CW-1:0]        w_nv;
    logic [CW-1:0]        w_ne;
    logic [sources_p-1:0] w_ready;
    logic [sources_p-1:0] w_store;
    logic [PW-1:0]        w_wr_idx [sources_p];
    logic [PW-1:0]        w_head1;
    logic                 w_v0;
    logic                 w_v1;
    logic                 w_waw;
    logic [CW-1:0]        w_deq;

    // Ready only looks at older sources, so x0 writes still count against free space here.
    always_comb begin
        w_free = CW'(els_p) - r_count;
        w_nv   = {CW{1'b0}};
        w_ne   = {CW{1'b0}};
        for (int i = 0; i < sources_p; i++) begin
            w_ready[i]  = (w_nv < w_free);
            w_store[i]  = src_v_i[i] & w_ready[i]
                        & ~(zero_x0_p & (src_addr_i[i*AW +: AW] == {AW{1'b0}}));
            w_wr_idx[i] = r_tail + w_ne[PW-1:0];
            w_nv        = w_nv + CW'(src_v_i[i]);
            w_ne        = w_ne + CW'(w_store[i]);
        end
    end

    assign w_head1 = r_head + PW'(1'b1);
    assign w_v0    = (r_count != {CW{1'b0}});
    assign w_v1    = (r_count >= CW'(2'd2));
    assign w_waw   = w_v0 & w_v1 & (r_mem_addr[r_head] == r_mem_addr[w_head1]);
    assign w_deq   = CW'({w_v1, w_v0 & ~w_v1});

    assign src_ready_o = w_ready;
    assign rd_w_v_o    = {w_v1, w_v0 & ~w_waw} & {2{~reset_i}};
    assign rd_addr_o   = {r_mem_addr[w_head1], r_mem_addr[r_head]};
    assign rd_data_o   = {r_mem_data[w_head1], r_mem_data[r_head]};
    assign empty_o     = (r_count == {CW{1'b0}});
    assign count_o     = r_count;

    // Pointer and occupancy update; drained entries always pop because the register file never stalls.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_head  <= r_head + w_deq[PW-1:0];
            r_tail  <= r_tail + w_ne[PW-1:0];
            r_count <= r_count - w_deq + w_ne;
        end
    end

    // Entry storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < sources_p; i++) begin
            if (w_store[i]) begin
                r_mem_addr[w_wr_idx[i]] <= src_addr_i[i*AW +: AW];
                r_mem_data[w_wr_idx[i]] <= src_data_i[i*DW +: DW];
            end
        end
    end

`ifdef BP_BE_WB_MERGE_STATS_EN
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_waw;
    logic [31:0] r_stat_stall;
    logic [31:0] w_wr_inc;

    assign w_wr_inc = 32'(rd_w_v_o[0]) + 32'(rd_w_v_o[1]);

    // Saturating event counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stat_writes <= 32'd0;
            r_stat_waw    <= 32'd0;
            r_stat_stall  <= 32'd0;
        end else begin
            if (r_stat_writes > (32'hFFFF_FFFF - w_wr_inc)) begin
                r_stat_writes <= 32'hFFFF_FFFF;
            end else begin
                r_stat_writes <= r_stat_writes + w_wr_inc;
            end
            if (w_waw && (r_stat_waw != 32'hFFFF_FFFF)) begin
                r_stat_waw <= r_stat_waw + 32'd1;
            end
            if ((|(src_v_i & ~w_ready)) && (r_stat_stall != 32'hFFFF_FFFF)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_writes_o    = r_stat_writes;
    assign stat_waw_drops_o = r_stat_waw;
    assign stat_stall_o     = r_stat_stall;
`endif

endmodule
